// File: rtl/rsa_mod_mult.sv
// Bit-serial interleaved modular multiplier: result = (a * b) mod n on 2*WIDTH-bit operands.
// Define RSA_CONST_TIME_EN for fixed N-step latency; otherwise leading zeros of b are skipped.
module rsa_mod_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic [2*WIDTH-1:0] n,
    output logic [2*WIDTH-1:0] result,
    output logic               finish,
    output logic               busy
);
    localparam int N  = 2 * WIDTH;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [N-1:0]  a_r, b_r, n_r, r_acc;
    logic [IW-1:0] idx, start_idx;

    logic [N:0]    t2, t2_sub, u_sum, u_sub;
    logic [N-1:0]  t, u_red, u;

`ifdef RSA_CONST_TIME_EN
    assign start_idx = IW'(N - 1);
`else
    // Priority encoder: highest set bit of b, 0 when b == 0.
    always_comb begin
        start_idx = '0;
        for (int k = 0; k < N; k++)
            if (b[k]) start_idx = IW'(k);
    end
`endif

    // Both reductions are always computed and muxed so every step looks the same.
    always_comb begin
        t2     = {r_acc, 1'b0};
        t2_sub = t2 - {1'b0, n_r};
        t      = (t2 >= {1'b0, n_r}) ? t2_sub[N-1:0] : t2[N-1:0];
        u_sum  = {1'b0, t} + {1'b0, a_r};
        u_sub  = u_sum - {1'b0, n_r};
        u_red  = (u_sum >= {1'b0, n_r}) ? u_sub[N-1:0] : u_sum[N-1:0];
        u      = b_r[idx] ? u_red : t;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (idx == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            n_r    <= '0;
            r_acc  <= '0;
            idx    <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                a_r   <= a;
                b_r   <= b;
                n_r   <= n;
                r_acc <= '0;
                idx   <= start_idx;
            end else if (state == RUN) begin
                r_acc <= u;
                idx   <= idx - 1'b1;
                if (idx == '0) result <= u;
            end
        end
    end

    assign finish = (state == DONE);
    assign busy   = (state == RUN);
endmodule

// File: tb/tb_rsa_mod_mult.sv
// Scoreboard bench for rsa_mod_mult (WIDTH=8); expectations follow RSA_CONST_TIME_EN if defined.
module tb_rsa_mod_mult;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [15:0] a, b, n;
    logic [15:0] result;
    logic        finish, busy;

    typedef struct {
        logic [15:0] res;
        int          k;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    rsa_mod_mult #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .n(n),
        .result(result), .finish(finish), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int exp_k(input logic [15:0] bv);
`ifdef RSA_CONST_TIME_EN
        return 16;
`else
        int m = 0;
        for (int i = 0; i < 16; i++)
            if (bv[i]) m = i;
        return m + 1;
`endif
    endfunction

    function automatic logic [15:0] model(input logic [15:0] av, bv, nv);
        longint unsigned p = (longint'(av) * longint'(bv)) % longint'(nv);
        return p[15:0];
    endfunction

    // Called on a negedge with DUT idle. With inject, a (3,3,7) start is
    // held high from RUN through DONE and must neither restart nor alter the result.
    task automatic do_op(input string tag, input logic [15:0] av, bv, nv, input bit inject);
        exp_t e;
        int   lat = 0;
        int   bcnt = 0;
        a = av; b = bv; n = nv; start = 1'b1;
        @(posedge clk);
        e.res = model(av, bv, nv);
        e.k   = exp_k(bv);
        exp_q.push_back(e);
        #1 start = 1'b0;
        @(negedge clk);
        while (!finish && lat < 100) begin
            if (busy) bcnt++;
            if (inject && lat == 2) begin
                a = 16'd3; b = 16'd3; n = 16'd7; start = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_finish"}, finish, 1);
        e = exp_q.pop_front();
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_latency"}, lat, e.k);
        chk({tag, "_busy_cycles"}, bcnt, e.k);
        @(negedge clk);
        chk({tag, "_finish_pulse"}, finish, 0);
        chk({tag, "_no_restart"}, busy, 0);
        chk({tag, "_result_held"}, result, e.res);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; n = 16'd2;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 0);
        chk("reset_finish", finish, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("small",    16'd5,    16'd7,    16'd11,   1'b0);
        do_op("fullb",    16'h1234, 16'hFFFF, 16'hFFF1, 1'b0);
        do_op("wide",     16'hFFFE, 16'hFFFE, 16'hFFFF, 1'b0);
        do_op("bzero",    16'd100,  16'd0,    16'd200,  1'b0);
        do_op("ignored",  16'd5,    16'd7,    16'd11,   1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] nv, av, bv;
            nv = 16'($urandom_range(65535, 2));
            av = 16'($urandom_range(32'(nv) - 1, 0));
            bv = 16'($urandom);
            do_op("random", av, bv, nv, 1'b0);
        end

        // Abort mid-run: no finish, outputs back to reset values.
        begin
            int fins = 0;
            a = 16'd5; b = 16'hFFFF; n = 16'd11; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (5) @(negedge clk);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_result", result, 0);
            chk("abort_busy", busy, 0);
            rst_n = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (finish) fins++;
            end
            chk("abort_no_finish", fins, 0);
        end
        do_op("after_abort", 16'd3, 16'd3, 16'd7, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
